// File: rtl/grid_ram_arbiter.sv
// Per-cycle slot arbiter for the 20x20 grid cell RAM: clear sequencer > video > host.
// Owner tags ride a 2-stage pipeline alongside the RAM read so data returns to its requester.
module grid_ram_arbiter #(
  parameter int GRID_W    = 20,
  parameter int GRID_H    = 20,
  parameter int DATA_W    = 4,
  parameter int ADDR_W    = 9,
  parameter int CLEAR_VAL = 0,
  parameter int COORD_W   = 5
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_vid_active,
  input  logic [COORD_W-1:0] i_vid_grid_x,
  input  logic [COORD_W-1:0] i_vid_grid_y,
  output logic [DATA_W-1:0]  o_vid_data,
  output logic               o_vid_valid,
  input  logic               i_host_req,
  input  logic               i_host_we,
  input  logic [COORD_W-1:0] i_host_x,
  input  logic [COORD_W-1:0] i_host_y,
  input  logic [DATA_W-1:0]  i_host_wdata,
  output logic               o_host_ack,
  output logic               o_host_err,
  output logic [DATA_W-1:0]  o_host_rdata,
  input  logic               i_clear_req,
  output logic               o_clear_done,
  output logic [ADDR_W-1:0]  o_ram_addr,
  output logic               o_ram_we,
  output logic [DATA_W-1:0]  o_ram_wdata,
  input  logic [DATA_W-1:0]  i_ram_rdata
);

  localparam logic [ADDR_W-1:0]  LAST_CELL = ADDR_W'(GRID_W * GRID_H - 1);
  localparam logic [COORD_W-1:0] GW_C      = COORD_W'(GRID_W);
  localparam logic [COORD_W-1:0] GH_C      = COORD_W'(GRID_H);
  localparam logic [DATA_W-1:0]  CLR_D     = DATA_W'(CLEAR_VAL);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
  typedef enum logic [1:0] {TAG_NONE, TAG_VID, TAG_HOST} tag_t;

  state_t             r_state, w_state_nxt;
  logic [ADDR_W-1:0]  r_cnt, w_cnt_nxt;
  tag_t               r_tag1, r_tag2, w_tag1_nxt;
  logic               r_force1, r_force2, w_force_nxt;
  logic [DATA_W-1:0]  r_fval1, r_fval2, w_fval_nxt;
  logic [ADDR_W-1:0]  w_addr_nxt;
  logic               w_we_nxt;
  logic [DATA_W-1:0]  w_wdata_nxt;
  logic               w_wack_nxt;

  logic               w_vid_oor, w_host_oor, w_host_busy, w_host_elig;
  logic [ADDR_W-1:0]  w_vid_addr, w_host_addr;

  assign w_vid_oor   = (i_vid_grid_x >= GW_C) || (i_vid_grid_y >= GH_C);
  assign w_host_oor  = (i_host_x >= GW_C) || (i_host_y >= GH_C);
  assign w_vid_addr  = ADDR_W'(i_vid_grid_y) * ADDR_W'(GRID_W) + ADDR_W'(i_vid_grid_x);
  assign w_host_addr = ADDR_W'(i_host_y) * ADDR_W'(GRID_W) + ADDR_W'(i_host_x);
  // A host read is in flight while its tag sits in either pipeline stage.
  assign w_host_busy = (r_tag1 == TAG_HOST) || (r_tag2 == TAG_HOST);
  assign w_host_elig = i_host_req && !w_host_busy && !o_host_ack;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = o_ram_addr;
    w_we_nxt    = 1'b0;
    w_wdata_nxt = o_ram_wdata;
    w_tag1_nxt  = TAG_NONE;
    w_force_nxt = 1'b0;
    w_fval_nxt  = '0;
    w_wack_nxt  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_we_nxt    = 1'b1;
        w_addr_nxt  = r_cnt;
        w_wdata_nxt = CLR_D;
        if (r_cnt == LAST_CELL) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
        // Video never touches the RAM while clearing; it sees the clear value.
        if (i_vid_active) begin
          w_tag1_nxt  = TAG_VID;
          w_force_nxt = 1'b1;
          w_fval_nxt  = CLR_D;
        end
      end
      default: begin
        if (i_clear_req) begin
          w_state_nxt = ST_CLEAR;
          w_cnt_nxt   = '0;
        end
        if (i_vid_active) begin
          w_tag1_nxt = TAG_VID;
          if (w_vid_oor) w_force_nxt = 1'b1;
          else           w_addr_nxt  = w_vid_addr;
        end else if (w_host_elig) begin
          if (w_host_oor) begin
            w_tag1_nxt  = TAG_HOST;
            w_force_nxt = 1'b1;
          end else if (i_host_we) begin
            w_addr_nxt  = w_host_addr;
            w_we_nxt    = 1'b1;
            w_wdata_nxt = i_host_wdata;
            w_wack_nxt  = 1'b1;
          end else begin
            w_addr_nxt = w_host_addr;
            w_tag1_nxt = TAG_HOST;
          end
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state      <= ST_CLEAR;
      r_cnt        <= '0;
      r_tag1       <= TAG_NONE;
      r_tag2       <= TAG_NONE;
      r_force1     <= 1'b0;
      r_force2     <= 1'b0;
      r_fval1      <= '0;
      r_fval2      <= '0;
      o_ram_addr   <= '0;
      o_ram_we     <= 1'b0;
      o_ram_wdata  <= '0;
      o_vid_data   <= '0;
      o_vid_valid  <= 1'b0;
      o_host_ack   <= 1'b0;
      o_host_err   <= 1'b0;
      o_host_rdata <= '0;
      o_clear_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_tag1       <= w_tag1_nxt;
      r_tag2       <= r_tag1;
      r_force1     <= w_force_nxt;
      r_force2     <= r_force1;
      r_fval1      <= w_fval_nxt;
      r_fval2      <= r_fval1;
      o_ram_addr   <= w_addr_nxt;
      o_ram_we     <= w_we_nxt;
      o_ram_wdata  <= w_wdata_nxt;
      o_clear_done <= (r_state == ST_RUN) && (w_state_nxt == ST_RUN);
      o_vid_valid  <= (r_tag2 == TAG_VID);
      if (r_tag2 == TAG_VID)
        o_vid_data <= r_force2 ? r_fval2 : i_ram_rdata;
      o_host_ack   <= w_wack_nxt || (r_tag2 == TAG_HOST);
      o_host_err   <= (r_tag2 == TAG_HOST) && r_force2;
      if (r_tag2 == TAG_HOST)
        o_host_rdata <= r_force2 ? r_fval2 : i_ram_rdata;
    end
  end

endmodule

// File: tb/tb_grid_ram_arbiter.sv
// Directed bench for grid_ram_arbiter with a behavioural synchronous single-port RAM.
module tb_grid_ram_arbiter;
  logic       clk = 1'b0;
  logic       reset_n;
  logic       vid_active;
  logic [4:0] vid_x, vid_y;
  logic [3:0] vid_data;
  logic       vid_valid;
  logic       host_req, host_we;
  logic [4:0] host_x, host_y;
  logic [3:0] host_wdata, host_rdata;
  logic       host_ack, host_err;
  logic       clear_req, clear_done;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [3:0] ram_wdata, ram_rdata;
  logic [3:0] mem [0:511];

  int n_chk  = 0;
  int n_pass = 0;
  int bad;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  grid_ram_arbiter dut (
    .i_clk(clk), .i_reset_n(reset_n),
    .i_vid_active(vid_active), .i_vid_grid_x(vid_x), .i_vid_grid_y(vid_y),
    .o_vid_data(vid_data), .o_vid_valid(vid_valid),
    .i_host_req(host_req), .i_host_we(host_we), .i_host_x(host_x), .i_host_y(host_y),
    .i_host_wdata(host_wdata), .o_host_ack(host_ack), .o_host_err(host_err),
    .o_host_rdata(host_rdata), .i_clear_req(clear_req), .o_clear_done(clear_done),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wdata(ram_wdata),
    .i_ram_rdata(ram_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs clear cycles first..399, counting any cycle that is not a proper clear write.
  task automatic run_clear(input int first, input int pulse_at, output int nbad);
    nbad = 0;
    for (int i = first; i < 400; i++) begin
      clear_req = (i == pulse_at);
      step();
      if (ram_we !== 1'b1 || ram_addr !== 9'(i) || ram_wdata !== 4'd0 ||
          host_ack !== 1'b0 || clear_done !== 1'b0) nbad++;
    end
    clear_req = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; vid_active = 1'b0; vid_x = '0; vid_y = '0;
    host_req = 1'b0; host_we = 1'b0; host_x = '0; host_y = '0; host_wdata = '0;
    clear_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_we", ram_we, 0);
    chk("rst_ack", host_ack, 0);
    chk("rst_vid_valid", vid_valid, 0);
    chk("rst_clear_done", clear_done, 0);

    // Power-up clear: 400 writes of zero, then done.
    reset_n = 1'b1;
    run_clear(0, -1, bad);
    chk("init_clear_bad_cycles", bad, 0);
    step();
    chk("init_clear_done", clear_done, 1);
    chk("init_clear_we_off", ram_we, 0);

    // Host write (3,2)=5 then read back.
    host_req = 1'b1; host_we = 1'b1; host_x = 5'd3; host_y = 5'd2; host_wdata = 4'd5;
    step();
    chk("wr_addr", ram_addr, 43);
    chk("wr_we", ram_we, 1);
    chk("wr_ack", host_ack, 1);
    host_req = 1'b0;
    step();
    chk("wr_we_one_cycle", ram_we, 0);
    chk("wr_ack_one_cycle", host_ack, 0);
    host_req = 1'b1; host_we = 1'b0;
    step();
    chk("rd_addr", ram_addr, 43);
    chk("rd_ack_e0", host_ack, 0);
    step();
    chk("rd_ack_e1", host_ack, 0);
    step();
    chk("rd_ack_e2", host_ack, 1);
    chk("rd_data", host_rdata, 5);
    chk("rd_err", host_err, 0);
    host_req = 1'b0;
    step();
    chk("rd_ack_drop", host_ack, 0);
    chk("rd_data_held", host_rdata, 5);

    // Host starved by active video for 100 cycles.
    vid_active = 1'b1; vid_x = 5'd0; vid_y = 5'd0;
    host_req = 1'b1; host_we = 1'b1; host_x = 5'd1; host_y = 5'd0; host_wdata = 4'd9;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (host_ack !== 1'b0 || ram_we !== 1'b0) bad++;
    end
    chk("starve_no_host", bad, 0);
    chk("starve_vid_valid", vid_valid, 1);
    chk("starve_vid_data", vid_data, 0);
    vid_active = 1'b0;
    step();
    chk("starve_served_ack", host_ack, 1);
    chk("starve_served_addr", ram_addr, 1);
    chk("starve_served_wdata", ram_wdata, 9);
    host_req = 1'b0;
    step();

    // Write 0xA into (19,19), then interleave video reads of (3,2) with a host read of (19,19).
    host_req = 1'b1; host_we = 1'b1; host_x = 5'd19; host_y = 5'd19; host_wdata = 4'hA;
    step();
    chk("wr399_addr", ram_addr, 399);
    host_req = 1'b0;
    step();
    vid_active = 1'b1; vid_x = 5'd3; vid_y = 5'd2;
    host_req = 1'b1; host_we = 1'b0;
    step();
    chk("tog_vid_addr", ram_addr, 43);
    vid_active = 1'b0;
    step();
    chk("tog_host_addr", ram_addr, 399);
    vid_active = 1'b1;
    step();
    chk("tog_vid_valid_a", vid_valid, 1);
    chk("tog_vid_data_a", vid_data, 5);
    chk("tog_ack_early", host_ack, 0);
    vid_active = 1'b0;
    step();
    chk("tog_host_ack", host_ack, 1);
    chk("tog_host_rdata", host_rdata, 4'hA);
    chk("tog_vid_gap", vid_valid, 0);
    host_req = 1'b0;
    step();
    chk("tog_vid_valid_b", vid_valid, 1);
    chk("tog_vid_data_b", vid_data, 5);
    chk("tog_ack_single", host_ack, 0);

    // Clear request while running; video during clear returns the clear value.
    clear_req = 1'b1;
    step();
    chk("creq_done_low", clear_done, 0);
    clear_req = 1'b0;
    vid_active = 1'b1;
    step();
    chk("creq_first_addr", ram_addr, 0);
    chk("creq_first_we", ram_we, 1);
    vid_active = 1'b0;
    step();
    step();
    chk("clr_vid_valid", vid_valid, 1);
    chk("clr_vid_data", vid_data, 0);
    run_clear(3, 100, bad);
    chk("creq_clear_bad_cycles", bad, 0);
    step();
    chk("creq_clear_done", clear_done, 1);

    // Re-seed (3,2)=6 and let video latch it.
    host_req = 1'b1; host_we = 1'b1; host_x = 5'd3; host_y = 5'd2; host_wdata = 4'd6;
    step();
    host_req = 1'b0;
    vid_active = 1'b1;
    step();
    vid_active = 1'b0;
    step();
    step();
    chk("seed_vid_data", vid_data, 6);

    // Out-of-range host write and video read.
    host_req = 1'b1; host_we = 1'b1; host_x = 5'd20; host_y = 5'd0; host_wdata = 4'd7;
    bad = 0;
    step();
    if (ram_we !== 1'b0) bad++;
    chk("oor_ack_e0", host_ack, 0);
    step();
    if (ram_we !== 1'b0) bad++;
    step();
    if (ram_we !== 1'b0) bad++;
    chk("oor_no_we", bad, 0);
    chk("oor_ack", host_ack, 1);
    chk("oor_err", host_err, 1);
    chk("oor_rdata", host_rdata, 0);
    host_req = 1'b0;
    step();
    chk("oor_err_drop", host_err, 0);
    vid_active = 1'b1; vid_x = 5'd3; vid_y = 5'd25;
    step();
    vid_active = 1'b0;
    step();
    step();
    chk("oor_vid_valid", vid_valid, 1);
    chk("oor_vid_data", vid_data, 0);

    // Reset right after a host read wins: no ack, full clear restarts.
    host_req = 1'b1; host_we = 1'b0; host_x = 5'd3; host_y = 5'd2;
    step();
    chk("rstmid_rd_addr", ram_addr, 43);
    reset_n = 1'b0;
    host_req = 1'b0;
    step();
    chk("rstmid_ack_in_reset", host_ack, 0);
    reset_n = 1'b1;
    run_clear(0, -1, bad);
    chk("rstmid_clear_bad_cycles", bad, 0);
    step();
    chk("rstmid_clear_done", clear_done, 1);
    chk("rstmid_no_late_ack", host_ack, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
